// File: rtl/spindash_pkg.sv
// Shared constants and types for the Spindash I2S transmitter.
package spindash_pkg;
  localparam int unsigned SLOT_BITS         = 24;
  localparam int unsigned FRAME_BITS        = 48;
  localparam int unsigned BCLK_HALF_DEFAULT = 9;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;
endpackage

// File: rtl/spindash_i2s_fmt.sv
// Per-channel formatter: sign-extend to a 24-bit slot, then align and apply gain.
// SPINDASH_I2S_SAT_EN selects saturation on overflow; otherwise the result wraps.
module spindash_i2s_fmt
  import spindash_pkg::*;
#(
  parameter int WIDTH      = 19,
  parameter int GAIN_SHIFT = 0
) (
  input  logic [WIDTH-1:0]     i_sample,
  output logic [SLOT_BITS-1:0] o_slot
);
  localparam int unsigned SHIFT = SLOT_BITS - WIDTH + GAIN_SHIFT;

`ifdef SPINDASH_I2S_SAT_EN
  // 16 spare bits cover the largest possible shift (8 alignment + 7 gain).
  localparam int unsigned WIDE = SLOT_BITS + 16;

  logic signed [WIDE-1:0] w_wide;
  logic                   w_ovf;

  always_comb begin
    w_wide = WIDE'(signed'(i_sample)) <<< SHIFT;
    w_ovf  = w_wide[WIDE-1:SLOT_BITS-1] != {(WIDE-SLOT_BITS+1){w_wide[SLOT_BITS-1]}};
    if (!w_ovf)
      o_slot = w_wide[SLOT_BITS-1:0];
    else if (w_wide[WIDE-1])
      o_slot = 24'h800000;
    else
      o_slot = 24'h7FFFFF;
  end
`else
  logic signed [SLOT_BITS-1:0] w_ext;

  always_comb begin
    w_ext  = SLOT_BITS'(signed'(i_sample));
    o_slot = w_ext <<< SHIFT;
  end
`endif
endmodule

// File: rtl/spindash_i2s_tx.sv
// Philips I2S transmitter for the mixed Spindash output, with sticky under/overrun flags.
// Optional build macro: SPINDASH_I2S_SAT_EN (saturating sample formatter).
module spindash_i2s_tx
  import spindash_pkg::*;
#(
  parameter int WIDTH      = 19,
  parameter int GAIN_SHIFT = 0,
  parameter int BCLK_HALF  = BCLK_HALF_DEFAULT
) (
  input  logic             clk_jt,
  input  logic             rst,
  input  logic [WIDTH-1:0] snd_left,
  input  logic [WIDTH-1:0] snd_right,
  input  logic             snd_sample,
  input  logic             status_clr,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_sdata,
  output logic             underrun,
  output logic             overrun
);
  logic [7:0]            r_div;
  logic                  r_bclk, r_lrclk, r_sdata, r_und, r_ovr;
  logic [5:0]            r_bitcnt;
  logic                  r_run, r_pending, r_lsb, r_snd_d;
  logic [FRAME_BITS-1:0] r_frame;
  logic [SLOT_BITS-1:0]  r_hold_l, r_hold_r;

  logic [SLOT_BITS-1:0]  w_fmt_l, w_fmt_r;
  logic [5:0]            w_next_bc;
  logic                  w_fall, w_start, w_cap, w_und_set, w_ovr_set;

  spindash_i2s_fmt #(.WIDTH(WIDTH), .GAIN_SHIFT(GAIN_SHIFT)) u_fmt_l (
    .i_sample (snd_left),
    .o_slot   (w_fmt_l)
  );

  spindash_i2s_fmt #(.WIDTH(WIDTH), .GAIN_SHIFT(GAIN_SHIFT)) u_fmt_r (
    .i_sample (snd_right),
    .o_slot   (w_fmt_r)
  );

  // r_run forces the first fall after reset to open a fresh frame at bitcnt 0.
  always_comb begin
    w_fall    = r_bclk && (r_div == 8'(BCLK_HALF - 1));
    w_next_bc = '0;
    if (r_run && (r_bitcnt != 6'(FRAME_BITS - 1)))
      w_next_bc = r_bitcnt + 6'd1;
    w_start   = w_fall && (w_next_bc == '0);
    w_cap     = snd_sample && !r_snd_d;
    w_und_set = w_start && !r_pending;
    w_ovr_set = w_cap && r_pending && !w_start;
  end

  always_ff @(posedge clk_jt) begin
    if (rst) begin
      r_div     <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_bitcnt  <= '0;
      r_run     <= 1'b0;
      r_frame   <= '0;
      r_hold_l  <= '0;
      r_hold_r  <= '0;
      r_pending <= 1'b0;
      r_lsb     <= 1'b0;
      r_snd_d   <= 1'b0;
      r_und     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_snd_d <= snd_sample;

      if (r_div == 8'(BCLK_HALF - 1)) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 8'd1;
      end

      if (w_fall) begin
        r_run    <= 1'b1;
        r_bitcnt <= w_next_bc;
        r_lrclk  <= (w_next_bc >= 6'(SLOT_BITS)) ? SLOT_RIGHT : SLOT_LEFT;
        // Bit 47 goes out after the frame reloads, so its value is parked in r_lsb.
        if (w_next_bc == '0)
          r_sdata <= r_lsb;
        else
          r_sdata <= r_frame[6'(FRAME_BITS) - w_next_bc];
        if (w_next_bc == 6'(FRAME_BITS - 1))
          r_lsb <= r_frame[0];
      end

      if (w_start && r_pending)
        r_frame <= {r_hold_l, r_hold_r};

      if (w_cap) begin
        r_hold_l <= w_fmt_l;
        r_hold_r <= w_fmt_r;
      end

      if (w_cap)
        r_pending <= 1'b1;
      else if (w_start)
        r_pending <= 1'b0;

      if (w_und_set)
        r_und <= 1'b1;
      else if (status_clr)
        r_und <= 1'b0;

      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (status_clr)
        r_ovr <= 1'b0;
    end
  end

  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign underrun  = r_und;
  assign overrun   = r_ovr;
endmodule

// File: tb/tb_spindash_i2s_tx.sv
// Scoreboard bench for spindash_i2s_tx: a frame-level model queues expected words,
// an I2S receiver reassembles the serial stream and checks it.
`timescale 1ns/1ps
module tb_spindash_i2s_tx;
  localparam int W = 19;

  logic         clk_jt = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] snd_left = '0, snd_right = '0;
  logic         snd_sample = 1'b0, status_clr = 1'b0;
  logic         i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun;

  logic [W-1:0] f_in = '0;
  logic [23:0]  f_out;

  always #9 clk_jt = ~clk_jt;

  spindash_i2s_tx #(.WIDTH(W), .GAIN_SHIFT(0), .BCLK_HALF(9)) dut (
    .clk_jt     (clk_jt),
    .rst        (rst),
    .snd_left   (snd_left),
    .snd_right  (snd_right),
    .snd_sample (snd_sample),
    .status_clr (status_clr),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  spindash_i2s_fmt #(.WIDTH(W), .GAIN_SHIFT(3)) u_fmt_g3 (
    .i_sample (f_in),
    .o_slot   (f_out)
  );

  int          npass = 0, ntot = 0, nframes = 0;
  logic [47:0] exp_q[$];
  logic [47:0] cur_m;
  bit          und_m, ovr_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Two's-complement value scaled by 2^(24-W+g), then wrapped or clamped to 24 bits.
  function automatic logic [23:0] ref_fmt(input logic [W-1:0] x, input int g);
    longint v;
    v = longint'(x);
    if (x[W-1]) v = v - (longint'(1) << W);
    v = v * (longint'(1) << (24 - W + g));
`ifdef SPINDASH_I2S_SAT_EN
    if (v > 64'sd8388607) v = 64'sd8388607;
    else if (v < -64'sd8388608) v = -64'sd8388608;
`endif
    return v[23:0];
  endfunction

  // I2S receiver: bits sampled on BCLK rising; an LRCLK change marks the last bit of a slot.
  int          cyc = 0, last_b_rise = -1, last_lr_rise = -1;
  bit          prev_b = 0, prev_lr = 0, have_left = 0;
  logic [23:0] sr = '0, got_left = '0;
  logic [47:0] exp_w;

  always @(posedge clk_jt) begin
    #2;
    cyc++;
    if (rst) begin
      prev_b = 0; prev_lr = 0; have_left = 0; sr = '0;
      last_b_rise = -1; last_lr_rise = -1;
    end else begin
      if (i2s_bclk && !prev_b) begin
        if (last_b_rise >= 0) check("bclk_period", 64'(cyc - last_b_rise), 64'd18);
        last_b_rise = cyc;
        sr = {sr[22:0], i2s_sdata};
        if (i2s_lrclk != prev_lr) begin
          if (i2s_lrclk) begin
            if (last_lr_rise >= 0) check("lrclk_period", 64'(cyc - last_lr_rise), 64'd864);
            last_lr_rise = cyc;
            got_left  = sr;
            have_left = 1;
          end else if (have_left) begin
            have_left = 0;
            check("frame_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              exp_w = exp_q.pop_front();
              check("frame_word", {16'h0, got_left, sr}, {16'h0, exp_w});
              nframes++;
            end
          end
          prev_lr = i2s_lrclk;
        end
      end
      prev_b = i2s_bclk;
    end
  end

  task automatic do_reset();
    @(negedge clk_jt);
    rst = 1'b1;
    snd_sample = 1'b0;
    status_clr = 1'b0;
    @(posedge clk_jt);
    @(negedge clk_jt);
    check("rst_bclk",  64'(i2s_bclk),  64'd0);
    check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
    check("rst_sdata", 64'(i2s_sdata), 64'd0);
    check("rst_under", 64'(underrun),  64'd0);
    check("rst_over",  64'(overrun),   64'd0);
    rst = 1'b0;
    exp_q.delete();
    cur_m = '0;
    ovr_m = 0;
    exp_q.push_back(cur_m);
    repeat (17) @(posedge clk_jt);
    @(negedge clk_jt);
    check("first_bclk_high", 64'(i2s_bclk), 64'd1);
    @(posedge clk_jt);
    @(negedge clk_jt);
    check("first_fall_bclk",  64'(i2s_bclk),  64'd0);
    check("first_fall_lrclk", 64'(i2s_lrclk), 64'd0);
    und_m = 1;
  endtask

  task automatic strobe(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge clk_jt);
    snd_left   = l;
    snd_right  = r;
    snd_sample = 1'b1;
    repeat (4) @(posedge clk_jt);
    @(negedge clk_jt);
    snd_sample = 1'b0;
  endtask

  // One 864-cycle frame period starting just after a frame start.
  // kind: 0 = no sample, 1 = one sample, 2 = two samples 100 cycles apart.
  task automatic run_frame(input int kind, input bit clr,
                           input logic [W-1:0] l1, input logic [W-1:0] r1,
                           input logic [W-1:0] l2, input logic [W-1:0] r2);
    int used;
    logic [47:0] nxt;
    nxt = cur_m;
    repeat (200) @(posedge clk_jt);
    used = 200;
    @(negedge clk_jt);
    check("underrun", 64'(underrun), 64'(und_m));
    check("overrun",  64'(overrun),  64'(ovr_m));
    if (clr) begin
      status_clr = 1'b1;
      @(posedge clk_jt);
      @(negedge clk_jt);
      status_clr = 1'b0;
      used++;
      und_m = 0;
      ovr_m = 0;
      check("clr_underrun", 64'(underrun), 64'd0);
      check("clr_overrun",  64'(overrun),  64'd0);
    end
    repeat (300 - used) @(posedge clk_jt);
    used = 300;
    if (kind >= 1) begin
      strobe(l1, r1);
      used += 4;
      nxt = {ref_fmt(l1, 0), ref_fmt(r1, 0)};
    end
    if (kind == 2) begin
      repeat (100) @(posedge clk_jt);
      strobe(l2, r2);
      used += 104;
      ovr_m = 1;
      nxt = {ref_fmt(l2, 0), ref_fmt(r2, 0)};
    end
    repeat (864 - used) @(posedge clk_jt);
    if (kind == 0) und_m = 1;
    cur_m = nxt;
    exp_q.push_back(cur_m);
  endtask

  task automatic run_random();
    int r;
    int kind;
    r = int'($urandom_range(0, 9));
    kind = (r < 2) ? 0 : (r == 2) ? 2 : 1;
    run_frame(kind, $urandom_range(0, 3) == 0,
              W'($urandom), W'($urandom), W'($urandom), W'($urandom));
  endtask

  initial begin
    logic [W-1:0] fv[4];
    fv[0] = 19'h3FFFF; fv[1] = 19'h40000; fv[2] = 19'h00001; fv[3] = 19'h7FFFF;
    for (int i = 0; i < 12; i++) begin
      f_in = (i < 4) ? fv[i] : W'($urandom);
      #1;
      check("fmt_gain3", 64'(f_out), 64'(ref_fmt(f_in, 3)));
    end
    check("fmt_gain3_max", 64'(ref_fmt(19'h3FFFF, 3)),
`ifdef SPINDASH_I2S_SAT_EN
          64'h7FFFFF);
`else
          64'hFFFF00);
`endif

    do_reset();
    run_frame(1, 0, 19'h00001, 19'h7FFFF, '0, '0);
    check("model_035", 64'(cur_m), 64'h000020FFFFE0);
    run_frame(2, 0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    run_frame(0, 0, '0, '0, '0, '0);
    run_frame(0, 1, '0, '0, '0, '0);
    for (int i = 4; i < 40; i++) run_random();

    // Reset roughly at bitcnt 30 of a frame in progress.
    repeat (545) @(posedge clk_jt);
    do_reset();
    for (int i = 0; i < 10; i++) run_random();
    repeat (20) @(posedge clk_jt);
    check("frames_seen", 64'(nframes), 64'd50);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, ntot);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spindash_i2s_tx.md
SPINDASH_I2S_TX -- requirements
Module: spindash_i2s_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 19, mixed-sample width (16 + clog2(chip count)); legal range 16..24.
REQ-002 SHALL have parameter GAIN_SHIFT, default 0, extra left shift applied after width alignment; legal range 0..7.
REQ-003 SHALL have parameter BCLK_HALF, default 9, clk_jt cycles per BCLK half-period.
REQ-004 clk_jt  input  1  master clock, 53.7037 MHz.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 snd_left  input  WIDTH  signed mixed left sample.
REQ-007 snd_right  input  WIDTH  signed mixed right sample.
REQ-008 snd_sample  input  1  new-sample strobe; a 0->1 transition marks valid data.
REQ-009 status_clr  input  1  clears sticky flags.
REQ-010 i2s_bclk  output  1  bit clock, clk_jt/(2*BCLK_HALF).
REQ-011 i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-012 i2s_sdata  output  1  serial data, Philips I2S, MSB first.
REQ-013 underrun  output  1  sticky: a frame started with no new sample.
REQ-014 overrun  output  1  sticky: a sample arrived while the previous one was still pending.

Function
REQ-015 Divider SHALL count 0..BCLK_HALF-1 and toggle i2s_bclk when it reaches BCLK_HALF-1; "fall" means the cycle in which i2s_bclk goes 1->0.
REQ-016 Frame SHALL be 48 BCLK (two 24-bit slots): 864 clk_jt cycles at defaults, equal to one snd_sample period.
REQ-017 bitcnt (0..47) SHALL advance on every fall and wrap 47->0.
REQ-018 At each fall, i2s_lrclk SHALL be set to 0 for new bitcnt 0..23 and to 1 for 24..47.
REQ-019 At each fall, i2s_sdata SHALL output frame bit (bitcnt-1) mod 48, where frame bit k = frame_word[47-k] and frame_word = {left24, right24}; this gives the one-BCLK MSB delay.
REQ-020 The bit emitted at bitcnt 0 SHALL be the LSB of the previous frame's right slot, held in a 1-bit register.
REQ-021 Edge detect: a snd_sample 0->1 transition, registered once, SHALL latch the formatted left and right samples into hold registers and set pending.
REQ-022 At the fall where bitcnt becomes 0, if pending is set: frame_word SHALL load from the hold registers and pending SHALL clear.
REQ-023 At the same fall, if pending is clear: frame_word SHALL be retained (repeat last frame) and underrun SHALL set.
REQ-024 A capture while pending is already set SHALL overwrite the hold registers and set overrun.
REQ-025 If a capture and a frame-start load occur in the same cycle, the load SHALL take the old hold data and pending SHALL remain set for the new sample.
REQ-026 Format: sign-extend the input to 24 bits, then shift left by (24-WIDTH+GAIN_SHIFT).
REQ-027 Sample-to-serial latency SHALL be at most one frame plus one BCLK from the snd_sample edge to its left-slot MSB.
REQ-028 status_clr SHALL clear both flags in the next cycle; a set event in the same cycle SHALL take priority over the clear.

Reset
REQ-029 While rst is high, at every clk_jt edge: i2s_bclk, i2s_lrclk, i2s_sdata, divider, bitcnt, frame_word, hold registers, pending, underrun and overrun SHALL all be 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately; after release, bitcnt 0 SHALL begin at the first fall and the first frame SHALL send zeros unless a capture precedes it.

Configuration
REQ-031 With SPINDASH_I2S_SAT_EN defined, the shifted value SHALL saturate to 24'h7FFFFF or 24'h800000 on overflow.
REQ-032 Without SPINDASH_I2S_SAT_EN, the shifted value SHALL keep its low 24 bits (wrap), with no saturation logic.

Structure
REQ-033 Package spindash_pkg SHALL hold SLOT_BITS=24, FRAME_BITS=48 and the default BCLK_HALF=9.
REQ-034 Formatting (extend/shift/saturate) SHALL live in a single combinational sub-module, spindash_i2s_fmt, instantiated once per channel.

Verification
REQ-035 Defaults; snd_left=19'h00001, snd_right=19'h7FFFF, one snd_sample edge -> next frame left slot 24'h000020, right slot 24'hFFFFE0, MSB one BCLK after the lrclk edge.
REQ-036 Free-running edges every 864 cycles -> bclk period 18 cycles, lrclk period 864, underrun and overrun remain 0 for 100 frames.
REQ-037 No snd_sample edges after the first -> previous frame_word repeats, underrun=1; status_clr pulse -> underrun=0 and then re-sets at the next frame start.
REQ-038 Two edges 100 cycles apart, both before a frame start -> overrun=1, the second sample is transmitted.
REQ-039 GAIN_SHIFT=3, input 19'h3FFFF: with SPINDASH_I2S_SAT_EN -> 24'h7FFFFF; without it -> 24'hFFFF00 (wrapped).
REQ-040 rst asserted for 1 cycle at bitcnt 30 -> all outputs 0 during reset, and the first fall after release starts bitcnt 0 with lrclk=0.
